seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller, successor to the fixed 8-digit scanner. Drives NUM_DIGITS common-cathode/anode digits from one packed segment bus. Adds a programmable per-digit slot length, an inter-digit blanking gap to prevent ghosting, skipping of disabled digits, frame-level PWM brightness and a frame-boundary strobe. Sits between the display-content logic (Morse decode/text buffer) and the board pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (>=1)
SEG_W, 8, segment lines per digit (incl. DP)
DIV_W, 16, width of slot-length config
BLANK_CYC, 1, dark cycles at start of each slot (0 = no gap)
BRIGHT_W, 3, brightness control width
CAT_ACTIVE_LOW, 1, 1: selected digit line driven 0
SEG_ACTIVE_HIGH, 1, 1: lit segment driven 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
div_cfg  in  DIV_W  slot length minus 1, in clk cycles
digit_en  in  NUM_DIGITS  per-digit scan enable
bright  in  BRIGHT_W  brightness; all-ones = always lit
seg_val  in  NUM_DIGITS*SEG_W  digit i at [i*SEG_W +: SEG_W], lit=1
seg_ctl  out  SEG_W  segment drive, polarity per SEG_ACTIVE_HIGH
cat  out  NUM_DIGITS  digit select, polarity per CAT_ACTIVE_LOW
cur_digit  out  max(1,clog2(NUM_DIGITS))  index of digit in current slot
frame_tick  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (rst=1 at clk edge): seg_ctl and cat inactive (cat all-ones if CAT_ACTIVE_LOW, else zeros; seg_ctl zeros if SEG_ACTIVE_HIGH, else ones). frame_tick=0, cur_digit=0, slot_cnt=0, pwm_cnt=0, state S_OFF. Reset mid-slot takes effect on that edge.
- All outputs are registered and updated on the same edge as the state; no extra lag.
- States: S_OFF, S_BLANK, S_ON.
- S_OFF: outputs inactive. When digit_en!=0: next edge enters slot of lowest enabled index (S_BLANK, or S_ON if BLANK_CYC=0). frame_tick pulses on that edge.
- Slot start: slot_cnt=0, latch div_lat=div_cfg, latch slot data seg_val[idx].
- Each cycle slot_cnt++. S_BLANK while slot_cnt<BLANK_CYC (outputs inactive, cur_digit=idx); S_ON otherwise.
- S_ON: cat selects idx only; seg_ctl = slot data if lit_frame, else inactive. cat stays asserted when not lit_frame.
- Slot end when slot_cnt==div_lat: next edge starts a slot for the next enabled index above idx, wrapping to the lowest enabled.
  - On wrap, frame_tick=1 for that cycle and pwm_cnt++ (mod 2^BRIGHT_W).
  - With a single enabled digit every slot is a frame.
- lit_frame = (bright==all-ones) or (pwm_cnt<bright). bright=0 -> dark.
- div_cfg+1<=BLANK_CYC: digits never lit; scan and frame_tick continue.
- digit_en sampled at slot boundaries, except all-zero: forces S_OFF on the next edge (outputs inactive, cur_digit=0).
- A digit disabled mid-slot finishes its slot.
- div_cfg change takes effect at the next slot start.

Optional Feature:
SEG_FRAME_LATCH_EN:
- Defined: full seg_val captured into a shadow register on each frame-start edge; all slots of a frame use the shadow, so frames are coherent.
- Undefined: no shadow; each slot samples seg_val[idx] live at slot start. Saves NUM_DIGITS*SEG_W flops.

Test Plan:
Common config for all scenarios: NUM_DIGITS=4, SEG_W=8, BLANK_CYC=1, BRIGHT_W=3, defaults otherwise; div_cfg=3.
1. Reset: rst high 3 cycles -> cat=4'b1111, seg_ctl=8'h00, frame_tick=0; same when rst is asserted mid-S_ON.
2. digit_en=4'hF, bright=7, seg_val=32'h44332211:
   - per digit 1 cycle cat=1111/seg=00, then 3 cycles cat=1110/seg=11.
   - then 1101/22, 1011/33, 0111/44.
   - frame_tick once per 16 cycles, on digit-0 slot start.
3. digit_en=4'b0101 -> only cat=1110/11 and 1011/33 slots; frame period 8 cycles; cur_digit alternates 0,2.
4. digit_en->0 mid-slot -> next cycle cat=1111, seg=00, no frame_tick. Re-enable 4'b0010 -> next edge starts digit-1 slot with frame_tick=1.
5. bright=4 -> segments lit in frames with pwm_cnt 0..3, dark 4..7; over 8 frames exactly 4 lit. bright=0 -> never lit.
6. With SEG_FRAME_LATCH_EN defined, change seg_val to 32'hDDCCBBAA during digit-1 slot -> rest of frame shows 22,33,44; next frame shows AA..DD. Undefined -> digit 2 shows CC in the same frame.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - multiplexed 7-segment scan controller.
//
// Scans NUM_DIGITS digits from one packed segment bus. Each digit owns a
// slot of div_cfg+1 clock cycles. The first BLANK_CYC cycles of the slot are
// dark so the previous digit's segments do not ghost onto the next digit.
// Disabled digits are skipped. Brightness is frame-level PWM: a frame is lit
// when pwm_cnt < bright, or always when bright is all-ones.
//
// Optional build macro SEG_FRAME_LATCH_EN: when defined, seg_val is captured
// into a shadow register at every frame start so all slots of one frame show
// a coherent snapshot. When undefined, each slot samples its digit live at
// slot start.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   div_cfg     slot length minus 1, in clk cycles
//   digit_en    per-digit scan enable
//   bright      brightness (all-ones = always lit, 0 = dark)
//   seg_val     digit i at [i*SEG_W +: SEG_W], lit = 1
//   seg_ctl     segment drive, polarity per SEG_ACTIVE_HIGH
//   cat         digit select, polarity per CAT_ACTIVE_LOW
//   cur_digit   index of the digit owning the current slot
//   frame_tick  one-cycle pulse at the start of each frame
//
// state   | meaning
// S_OFF   | no digit enabled, outputs inactive
// S_BLANK | start of a slot, digit index valid, outputs dark
// S_ON    | digit selected, segments driven when the frame is lit

module seg_scan_ctrl #(
    parameter int NUM_DIGITS      = 8,
    parameter int SEG_W           = 8,
    parameter int DIV_W           = 16,
    parameter int BLANK_CYC       = 1,
    parameter int BRIGHT_W        = 3,
    parameter int CAT_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_HIGH = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            div_cfg,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [BRIGHT_W-1:0]         bright,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_val,
    output logic [SEG_W-1:0]            seg_ctl,
    output logic [NUM_DIGITS-1:0]       cat,
    output logic [IDX_W-1:0]            cur_digit,
    output logic                        frame_tick
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    localparam logic [SEG_W-1:0]      SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? '0 : '1;
    localparam logic [NUM_DIGITS-1:0] CAT_OFF = (CAT_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [DIV_W-1:0]      BLANK_V = DIV_W'(BLANK_CYC);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DIV_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [DIV_W-1:0]        div_lat_q, div_lat_d;
    logic [SEG_W-1:0]        slot_dat_q, slot_dat_d;
    logic [BRIGHT_W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [SEG_W-1:0]        seg_ctl_q, seg_ctl_d;
    logic [NUM_DIGITS-1:0]   cat_q, cat_d;

    logic [NUM_DIGITS*SEG_W-1:0] seg_src;
    logic [IDX_W-1:0]        lowest_idx;
    logic [IDX_W-1:0]        above_idx;
    logic                    above_ok;
    logic                    slot_start;
    logic                    lit_frame;
    logic [NUM_DIGITS-1:0]   cat_on;
    logic [SEG_W-1:0]        dat_sel;

`ifdef SEG_FRAME_LATCH_EN
    logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (frame_tick_d) begin
            shadow_d = seg_val;
        end
        // The first slot of a frame must see the value being latched now.
        seg_src = frame_tick_d ? seg_val : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    always_comb begin
        seg_src = seg_val;
    end
`endif

    // Lowest enabled digit, and the nearest enabled digit above idx_q.
    // Descending loops let the smallest qualifying index win.
    always_comb begin
        lowest_idx = '0;
        above_idx  = '0;
        above_ok   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (digit_en[i]) begin
                lowest_idx = IDX_W'(i);
                if (IDX_W'(i) > idx_q) begin
                    above_idx = IDX_W'(i);
                    above_ok  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        slot_cnt_d   = slot_cnt_q + DIV_W'(1);
        div_lat_d    = div_lat_q;
        slot_dat_d   = slot_dat_q;
        pwm_cnt_d    = pwm_cnt_q;
        frame_tick_d = 1'b0;
        slot_start   = 1'b0;
        dat_sel      = '0;

        if (digit_en == '0) begin
            state_d    = S_OFF;
            idx_d      = '0;
            slot_cnt_d = '0;
        end else if (state_q == S_OFF) begin
            slot_start   = 1'b1;
            frame_tick_d = 1'b1;
            idx_d        = lowest_idx;
        end else if (slot_cnt_q == div_lat_q) begin
            slot_start = 1'b1;
            if (above_ok) begin
                idx_d = above_idx;
            end else begin
                idx_d        = lowest_idx;
                frame_tick_d = 1'b1;
                pwm_cnt_d    = pwm_cnt_q + BRIGHT_W'(1);
            end
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                dat_sel = seg_src[i*SEG_W +: SEG_W];
            end
        end

        if (slot_start) begin
            slot_cnt_d = '0;
            div_lat_d  = div_cfg;
            slot_dat_d = dat_sel;
        end

        if (digit_en != '0) begin
            state_d = (slot_cnt_d < BLANK_V) ? S_BLANK : S_ON;
        end
    end

    // Outputs are derived from next-state values so they change on the same
    // edge as the state register.
    always_comb begin
        lit_frame = (bright == '1) || (pwm_cnt_d < bright);
        cat_on    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cat_on[i] = 1'b1;
            end
        end

        cat_d     = CAT_OFF;
        seg_ctl_d = SEG_OFF;
        if (state_d == S_ON) begin
            cat_d = (CAT_ACTIVE_LOW != 0) ? ~cat_on : cat_on;
            if (lit_frame) begin
                seg_ctl_d = (SEG_ACTIVE_HIGH != 0) ? slot_dat_d : ~slot_dat_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OFF;
            idx_q        <= '0;
            slot_cnt_q   <= '0;
            div_lat_q    <= '0;
            slot_dat_q   <= '0;
            pwm_cnt_q    <= '0;
            frame_tick_q <= 1'b0;
            seg_ctl_q    <= SEG_OFF;
            cat_q        <= CAT_OFF;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            slot_cnt_q   <= slot_cnt_d;
            div_lat_q    <= div_lat_d;
            slot_dat_q   <= slot_dat_d;
            pwm_cnt_q    <= pwm_cnt_d;
            frame_tick_q <= frame_tick_d;
            seg_ctl_q    <= seg_ctl_d;
            cat_q        <= cat_d;
        end
    end

    assign seg_ctl    = seg_ctl_q;
    assign cat        = cat_q;
    assign cur_digit  = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: 4 digits, 8 segments, 1 blank cycle,
// 3-bit brightness, div_cfg = 3 unless noted.

module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] div_cfg;
    logic [3:0]  digit_en;
    logic [2:0]  bright;
    logic [31:0] seg_val;
    logic [7:0]  seg_ctl;
    logic [3:0]  cat;
    logic [1:0]  cur_digit;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS(4),
        .SEG_W(8),
        .DIV_W(16),
        .BLANK_CYC(1),
        .BRIGHT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .div_cfg(div_cfg),
        .digit_en(digit_en),
        .bright(bright),
        .seg_val(seg_val),
        .seg_ctl(seg_ctl),
        .cat(cat),
        .cur_digit(cur_digit),
        .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  en;
        logic [2:0]  br;
        logic [31:0] sv;
        logic [3:0]  cat;
        logic [7:0]  seg;
        logic [1:0]  cur;
        logic        ft;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] en, logic [2:0] br, logic [31:0] sv,
                                logic [3:0] c, logic [7:0] s, logic [1:0] cur,
                                logic ft);
        vec_t v;
        v.en = en; v.br = br; v.sv = sv; v.cat = c; v.seg = s; v.cur = cur; v.ft = ft;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] c, input logic [7:0] s,
                           input logic [1:0] cur, input logic ft);
        chk({tag, ".cat"}, {28'd0, cat}, {28'd0, c});
        chk({tag, ".seg"}, {24'd0, seg_ctl}, {24'd0, s});
        chk({tag, ".cur"}, {30'd0, cur_digit}, {30'd0, cur});
        chk({tag, ".ft"},  {31'd0, frame_tick}, {31'd0, ft});
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        digit_en = 4'h0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    logic [3:0]  cat_on [4];
    logic [7:0]  seg_b  [4];
    logic [31:0] sv0;
    int          lit_cnt;
    logic        dark_ok;

    initial begin
        cat_on[0] = 4'hE; cat_on[1] = 4'hD; cat_on[2] = 4'hB; cat_on[3] = 4'h7;
        seg_b[0] = 8'h11; seg_b[1] = 8'h22; seg_b[2] = 8'h33; seg_b[3] = 8'h44;
        sv0 = 32'h44332211;

        // Full 4-digit frame, then switch to digits 0 and 2 only.
        tbl.push_back(mk(4'hF, 3'd7, sv0, 4'hF, 8'h00, 2'd0, 1'b1));
        for (int d = 0; d < 4; d++) begin
            if (d > 0) tbl.push_back(mk(4'hF, 3'd7, sv0, 4'hF, 8'h00, 2'(d), 1'b0));
            for (int k = 0; k < 3; k++)
                tbl.push_back(mk(4'hF, 3'd7, sv0, cat_on[d], seg_b[d], 2'(d), 1'b0));
        end
        tbl.push_back(mk(4'hF, 3'd7, sv0, 4'hF, 8'h00, 2'd0, 1'b1));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(4'h5, 3'd7, sv0, 4'hE, 8'h11, 2'd0, 1'b0));
        for (int f = 0; f < 2; f++) begin
            tbl.push_back(mk(4'h5, 3'd7, sv0, 4'hF, 8'h00, 2'd2, 1'b0));
            for (int k = 0; k < 3; k++) tbl.push_back(mk(4'h5, 3'd7, sv0, 4'hB, 8'h33, 2'd2, 1'b0));
            tbl.push_back(mk(4'h5, 3'd7, sv0, 4'hF, 8'h00, 2'd0, 1'b1));
            if (f == 0)
                for (int k = 0; k < 3; k++) tbl.push_back(mk(4'h5, 3'd7, sv0, 4'hE, 8'h11, 2'd0, 1'b0));
        end

        rst = 1'b1; digit_en = 4'h0; bright = 3'd7; seg_val = sv0; div_cfg = 16'd3;
        do_reset(3);
        chk_all("reset", 4'hF, 8'h00, 2'd0, 1'b0);

        foreach (tbl[i]) begin
            digit_en = tbl[i].en;
            bright   = tbl[i].br;
            seg_val  = tbl[i].sv;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].cat, tbl[i].seg, tbl[i].cur, tbl[i].ft);
        end

        // Disable everything mid-slot, then re-enable a single digit.
        tick();
        chk_all("pre_off", 4'hE, 8'h11, 2'd0, 1'b0);
        digit_en = 4'h0;
        tick();
        chk_all("off1", 4'hF, 8'h00, 2'd0, 1'b0);
        tick();
        chk_all("off2", 4'hF, 8'h00, 2'd0, 1'b0);
        digit_en = 4'h2;
        tick();
        chk_all("reen_blank", 4'hF, 8'h00, 2'd1, 1'b1);
        tick();
        chk_all("reen_on", 4'hD, 8'h22, 2'd1, 1'b0);

        // Reset while a digit is lit.
        rst = 1'b1;
        tick();
        chk_all("rst_mid_on", 4'hF, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;

        // PWM: bright=4 lights frames with pwm_cnt 0..3 only.
        do_reset(2);
        digit_en = 4'hF; bright = 3'd4; seg_val = sv0; div_cfg = 16'd3;
        lit_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 16; c++) begin
                tick();
                if (c == 0) chk($sformatf("pwm_ft%0d", k), {31'd0, frame_tick}, 32'd1);
                if (c == 1) begin
                    chk($sformatf("pwm_seg%0d", k), {24'd0, seg_ctl}, (k < 4) ? 32'h11 : 32'h00);
                    chk($sformatf("pwm_cat%0d", k), {28'd0, cat}, 32'hE);
                    if (seg_ctl == 8'h11) lit_cnt++;
                end
            end
        end
        chk("pwm_lit_count", lit_cnt, 32'd4);
        bright = 3'd0;
        dark_ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (seg_ctl !== 8'h00) dark_ok = 1'b0;
        end
        chk("bright0_dark", {31'd0, dark_ok}, 32'd1);

        // Slot no longer than the blank gap: never lit, scan still runs.
        do_reset(2);
        digit_en = 4'hF; bright = 3'd7; div_cfg = 16'd0;
        tick();
        chk_all("div0_c1", 4'hF, 8'h00, 2'd0, 1'b1);
        for (int d = 1; d < 4; d++) begin
            tick();
            chk_all($sformatf("div0_c%0d", d + 1), 4'hF, 8'h00, 2'(d), 1'b0);
        end
        tick();
        chk_all("div0_c5", 4'hF, 8'h00, 2'd0, 1'b1);

        // seg_val changes during the digit-1 slot.
        do_reset(2);
        digit_en = 4'hF; bright = 3'd7; div_cfg = 16'd3; seg_val = sv0;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 6) seg_val = 32'hDDCCBBAA;
`ifdef SEG_FRAME_LATCH_EN
            if (e == 10) chk("latch_d2", {24'd0, seg_ctl}, 32'h33);
            if (e == 14) chk("latch_d3", {24'd0, seg_ctl}, 32'h44);
`else
            if (e == 10) chk("live_d2", {24'd0, seg_ctl}, 32'hCC);
            if (e == 14) chk("live_d3", {24'd0, seg_ctl}, 32'hDD);
`endif
            if (e == 18) chk("next_d0", {24'd0, seg_ctl}, 32'hAA);
            if (e == 22) chk("next_d1", {24'd0, seg_ctl}, 32'hBB);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
